issue_queue_port: RTL and testbench
===================================

Name: issue_queue_port

Overview:
- Single-port out-of-order issue queue feeding one lane of the operand-read stage.
- Buffers renamed uops and tracks operand readiness by snooping writeback tags.
- Each cycle, selects one ready uop and presents it registered as `IS_UOp` on `OUT_uop`.
- Honours the downstream per-lane stall and branch-misprediction flushes.

Parameters:
- NUM_ENTRIES, 8, queue depth (power of two, ≥2).
- NUM_WBS, 4, number of writeback ports snooped for wakeup.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- IN_valid  in  1  enqueue request.
- IN_uop  in  IS_UOp  uop to enqueue.
- IN_availA  in  1  operand A ready at dispatch.
- IN_availB  in  1  operand B ready at dispatch.
- OUT_full  out  1  queue cannot accept an enqueue this cycle.
- OUT_freeCnt  out  $clog2(NUM_ENTRIES)+1  free entry count.
- IN_resultUOps  in  ResultUOp[NUM_WBS]  writeback snoop for wakeup.
- IN_branch  in  BranchProv  flush: taken, sqN.
- IN_stall  in  1  downstream lane stalled; hold OUT_uop.
- OUT_uop  out  IS_UOp  issued uop; valid field qualifies.

Behaviour:
- Reset: all entries invalid; OUT_uop.valid=0 (other fields x); OUT_full=0; OUT_freeCnt=NUM_ENTRIES.
- Operand readiness per entry:
  - availA/availB set if the tag MSB is 1 (constant/immediate), if the IN_avail bit is set, or on wakeup.
  - Wakeup: any IN_resultUOps[k].valid with tagDst==tag and tagDst MSB==0.
  - A wakeup in the same cycle as enqueue is captured.
- Enqueue: accepted when IN_valid && !OUT_full; written to the lowest-index free entry at the clock edge. OUT_full is combinational from registered occupancy (count==NUM_ENTRIES).
- Select: among valid entries with both operands ready, pick per selection policy; at most one per cycle.
- Issue, when !IN_stall:
  - OUT_uop <= selected entry with valid=1, and that entry is freed at the same edge.
  - If nothing is selected, OUT_uop.valid <= 0.
- Stall: when IN_stall, OUT_uop holds and no entry is freed (no issue).
- Latency: enqueue at edge E with both operands ready gives OUT_uop valid after edge E+1 (earliest). A wakeup observed in cycle C gives issue visible after the edge ending cycle C.
- Flush (IN_branch.taken), with younger defined as $signed(sqN - IN_branch.sqN) > 0:
  - Invalidate every younger entry.
  - Drop a younger enqueue that arrives in the flush cycle.
  - Clear OUT_uop.valid if OUT_uop is younger, even when stalled.
  - Older or equal uops are unaffected; selection of a younger entry is suppressed that cycle.
- Simultaneous enqueue and issue: when full, the issuing entry does not make room in the same cycle; OUT_full stays registered-based.
- sqN comparisons always use signed wrap-around difference.
- Reset mid-operation discards all contents; no partial issue.

Optional Feature:
- Macro: IQ_OLDEST_FIRST_EN.
- Defined: select the ready entry with the oldest sqN, using pairwise signed sqN comparisons.
- Undefined: select the lowest-index ready entry (fixed priority); smaller timing, no age guarantee.

Decomposition:
- Shared package:
  - IQEntry struct: valid, availA, availB, IS_UOp.
  - IQ_IDX_W = $clog2(NUM_ENTRIES).
  - Signed-age compare function.
- Sub-module `iq_age_select`: ready vector plus sqN array in, one-hot grant and valid out. Contains both policies under the macro.

Test Plan:
- Reset, then enqueue 1 uop with availA=availB=1, stall=0 → OUT_uop.valid=1 with matching sqN one edge later; freeCnt returns to 8.
- Enqueue uop with tagA=5, availA=0; drive IN_resultUOps[2] {valid=1, tagDst=5} 3 cycles later → issue the edge after the wakeup, not before.
- Fill 8 entries → OUT_full=1, 9th IN_valid ignored; issue one → OUT_full=0 next cycle.
- With IQ_OLDEST_FIRST_EN, ready sqNs 12 (entry 3) and 10 (entry 6) → sqN 10 issues first. Without the macro → entry 3 (sqN 12) issues first.
- Entries sqN 4, 7, 9 and OUT_uop sqN 8 stalled; branch taken sqN 6 → entries 7 and 9 cleared, OUT_uop.valid=0, sqN 4 survives.
- Stall held 3 cycles with OUT_uop valid → value unchanged; freeCnt unchanged; after release, the next ready uop issues.

Source files
------------

// File: rtl/issue_queue_port_pkg.sv
// Shared types for the single-lane issue queue: uop, writeback snoop, branch and entry structs,
// plus the signed wrap-around age compare used for flush and oldest-first selection.
package issue_queue_port_pkg;

    localparam int SQN_W           = 7;
    localparam int TAG_W           = 7;
    localparam int NUM_ENTRIES_DEF = 8;
    localparam int IQ_IDX_W        = $clog2(NUM_ENTRIES_DEF);

    typedef struct packed {
        logic             valid;
        logic [SQN_W-1:0] sqN;
        logic [TAG_W-1:0] tagA;
        logic [TAG_W-1:0] tagB;
        logic [TAG_W-1:0] tagDst;
        logic [5:0]       opcode;
    } IS_UOp;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tagDst;
    } ResultUOp;

    typedef struct packed {
        logic             taken;
        logic [SQN_W-1:0] sqN;
    } BranchProv;

    typedef struct packed {
        logic  valid;
        logic  availA;
        logic  availB;
        IS_UOp uop;
    } IQEntry;

    // a is younger than b when the wrapped difference a-b is strictly positive
    function automatic logic is_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return !d[SQN_W-1] && (d != '0);
    endfunction

endpackage

// File: rtl/issue_queue_port_age_select.sv
// One-hot grant over ready entries. IQ_OLDEST_FIRST_EN selects the oldest sqN (pairwise
// signed compares, ties to lower index); otherwise the lowest-index ready entry wins.
module iq_age_select
    import issue_queue_port_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     ready,
    input  logic [SQN_W-1:0] sqn [N],
    output logic [N-1:0]     grant,
    output logic             valid
);

`ifdef IQ_OLDEST_FIRST_EN
    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = ready[i];
            for (int j = 0; j < N; j++) begin
                if (j != i && ready[j]) begin
                    if (is_younger(sqn[i], sqn[j]) || (sqn[i] == sqn[j] && j < i))
                        grant[i] = 1'b0;
                end
            end
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign valid = |grant;

endmodule

// File: rtl/issue_queue_port.sv
// Single-port out-of-order issue queue: wakeup by writeback snoop, one registered issue per
// cycle, stall hold and branch flush. Selection policy set by IQ_OLDEST_FIRST_EN.
module issue_queue_port
    import issue_queue_port_pkg::*;
#(
    parameter int NUM_ENTRIES = NUM_ENTRIES_DEF,
    parameter int NUM_WBS     = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           IN_valid,
    input  IS_UOp                          IN_uop,
    input  logic                           IN_availA,
    input  logic                           IN_availB,
    output logic                           OUT_full,
    output logic [$clog2(NUM_ENTRIES):0]   OUT_freeCnt,
    input  ResultUOp                       IN_resultUOps [NUM_WBS],
    input  BranchProv                      IN_branch,
    input  logic                           IN_stall,
    output IS_UOp                          OUT_uop
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    IQEntry                 entries [NUM_ENTRIES];
    IS_UOp                  out_uop;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       free_idx;
    logic [NUM_ENTRIES-1:0] ready;
    logic [NUM_ENTRIES-1:0] flush_young;
    logic [NUM_ENTRIES-1:0] grant;
    logic                   grant_valid;
    logic [SQN_W-1:0]       sqn_arr [NUM_ENTRIES];
    IS_UOp                  sel_uop;
    IQEntry                 new_entry;
    logic                   issue;
    logic                   enq;

    function automatic logic wake(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_WBS; k++) begin
            if (IN_resultUOps[k].valid && IN_resultUOps[k].tagDst == tag && !tag[TAG_W-1])
                hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        cnt      = '0;
        free_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            cnt = cnt + CNT_W'(entries[i].valid);
            if (!entries[i].valid)
                free_idx = IDX_W'(i);
        end
    end

    assign OUT_full    = (cnt == CNT_W'(NUM_ENTRIES));
    assign OUT_freeCnt = CNT_W'(NUM_ENTRIES) - cnt;

    // Wakeups arriving this cycle count toward readiness so issue lands on the same edge
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            flush_young[i] = IN_branch.taken && is_younger(entries[i].uop.sqN, IN_branch.sqN);
            ready[i]       = entries[i].valid && !flush_young[i]
                          && (entries[i].availA || wake(entries[i].uop.tagA))
                          && (entries[i].availB || wake(entries[i].uop.tagB));
            sqn_arr[i]     = entries[i].uop.sqN;
        end
    end

    iq_age_select #(.N(NUM_ENTRIES)) u_select (
        .ready (ready),
        .sqn   (sqn_arr),
        .grant (grant),
        .valid (grant_valid)
    );

    always_comb begin
        sel_uop = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (grant[i])
                sel_uop = sel_uop | entries[i].uop;
        end
    end

    assign issue = grant_valid && !IN_stall;
    assign enq   = IN_valid && !OUT_full
                && !(IN_branch.taken && is_younger(IN_uop.sqN, IN_branch.sqN));

    always_comb begin
        new_entry           = '0;
        new_entry.valid     = 1'b1;
        new_entry.uop       = IN_uop;
        new_entry.uop.valid = 1'b1;
        new_entry.availA    = IN_availA || IN_uop.tagA[TAG_W-1] || wake(IN_uop.tagA);
        new_entry.availB    = IN_availB || IN_uop.tagB[TAG_W-1] || wake(IN_uop.tagB);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                entries[i] <= '0;
            out_uop <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (entries[i].valid) begin
                    if (wake(entries[i].uop.tagA))
                        entries[i].availA <= 1'b1;
                    if (wake(entries[i].uop.tagB))
                        entries[i].availB <= 1'b1;
                    if (flush_young[i] || (issue && grant[i]))
                        entries[i].valid <= 1'b0;
                end
            end
            // free_idx always points at an invalid entry, so it never collides with the updates above
            if (enq)
                entries[free_idx] <= new_entry;
            if (!IN_stall) begin
                out_uop       <= sel_uop;
                out_uop.valid <= grant_valid;
            end else if (IN_branch.taken && is_younger(out_uop.sqN, IN_branch.sqN)) begin
                out_uop.valid <= 1'b0;
            end
        end
    end

    assign OUT_uop = out_uop;

endmodule

// File: tb/tb_issue_queue_port.sv
// Self-checking bench for issue_queue_port: directed scenarios plus a randomized run against an
// array-based reference model of the queue rules.
module tb_issue_queue_port;
    import issue_queue_port_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      in_valid;
    IS_UOp     in_uop;
    logic      in_availA, in_availB;
    logic      out_full;
    logic [3:0] out_freeCnt;
    ResultUOp  wb [4];
    BranchProv br;
    logic      stall;
    IS_UOp     out_uop;

    int errors = 0;
    int checks = 0;

    // reference model state
    IS_UOp       m_uop [8];
    bit          m_v [8];
    bit          m_a [8];
    bit          m_b [8];
    IS_UOp       m_out;
    int unsigned next_sqn;

    always #5 clk = ~clk;

    issue_queue_port #(.NUM_ENTRIES(8), .NUM_WBS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .IN_valid      (in_valid),
        .IN_uop        (in_uop),
        .IN_availA     (in_availA),
        .IN_availB     (in_availB),
        .OUT_full      (out_full),
        .OUT_freeCnt   (out_freeCnt),
        .IN_resultUOps (wb),
        .IN_branch     (br),
        .IN_stall      (stall),
        .OUT_uop       (out_uop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_uop    = '0;
        in_availA = 1'b0;
        in_availB = 1'b0;
        for (int k = 0; k < 4; k++) wb[k] = '0;
        br    = '0;
        stall = 1'b0;
    endtask

    task automatic set_uop(input int sqn, input int ta, input int tb, input bit aa, input bit ab);
        in_uop        = '0;
        in_uop.valid  = 1'b1;
        in_uop.sqN    = 7'(sqn);
        in_uop.tagA   = 7'(ta);
        in_uop.tagB   = 7'(tb);
        in_uop.tagDst = 7'($urandom_range(0, 127));
        in_uop.opcode = 6'($urandom_range(0, 63));
        in_availA     = aa;
        in_availB     = ab;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // younger = wrapped distance from b to s lies in the positive half of the sqN ring
    function automatic bit m_young(input logic [6:0] s, input logic [6:0] b);
        int d;
        d = (int'(s) - int'(b) + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    function automatic bit m_wake(input logic [6:0] tag);
        if (tag >= 7'd64) return 1'b0;
        for (int k = 0; k < 4; k++)
            if (wb[k].valid && wb[k].tagDst == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_v[i] = 0; m_a[i] = 0; m_b[i] = 0; m_uop[i] = '0;
        end
        m_out = '0;
    endtask

    task automatic model_step();
        int  sel, slot, cnt;
        bit  full, rdy;
        if (rst) begin
            model_reset();
            return;
        end
        cnt = 0;
        slot = -1;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(m_v[i]);
            if (!m_v[i] && slot < 0) slot = i;
        end
        full = (cnt == 8);
        sel = -1;
        for (int i = 0; i < 8; i++) begin
            rdy = m_v[i] && (m_a[i] || m_wake(m_uop[i].tagA)) && (m_b[i] || m_wake(m_uop[i].tagB))
                  && !(br.taken && m_young(m_uop[i].sqN, br.sqN));
            if (rdy) begin
`ifdef IQ_OLDEST_FIRST_EN
                if (sel < 0 || m_young(m_uop[sel].sqN, m_uop[i].sqN)) sel = i;
`else
                if (sel < 0) sel = i;
`endif
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (m_v[i]) begin
                m_a[i] = m_a[i] | m_wake(m_uop[i].tagA);
                m_b[i] = m_b[i] | m_wake(m_uop[i].tagB);
                if (br.taken && m_young(m_uop[i].sqN, br.sqN)) m_v[i] = 0;
            end
        end
        if (!stall) begin
            if (sel >= 0) begin
                m_out = m_uop[sel];
                m_out.valid = 1'b1;
                m_v[sel] = 0;
            end else begin
                m_out.valid = 1'b0;
            end
        end else if (m_out.valid && br.taken && m_young(m_out.sqN, br.sqN)) begin
            m_out.valid = 1'b0;
        end
        if (in_valid && !full && !(br.taken && m_young(in_uop.sqN, br.sqN))) begin
            m_v[slot]   = 1;
            m_uop[slot] = in_uop;
            m_uop[slot].valid = 1'b1;
            m_a[slot] = in_availA || in_uop.tagA[6] || m_wake(in_uop.tagA);
            m_b[slot] = in_availB || in_uop.tagB[6] || m_wake(in_uop.tagB);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_uop.valid !== 1'b0 || out_full !== 1'b0 || out_freeCnt !== 4'd8) begin
            errors++;
            $display("FAIL reset: valid=%b full=%b freeCnt=%0d, want valid=0 full=0 freeCnt=8",
                     out_uop.valid, out_full, out_freeCnt);
        end
    endtask

    task automatic test_single_issue();
        do_reset();
        set_uop(1, 7'h40, 7'h41, 1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_uop.valid !== 1'b0 || out_freeCnt !== 4'd7) begin
            errors++;
            $display("FAIL single_enq: valid=%b freeCnt=%0d, want 0/7", out_uop.valid, out_freeCnt);
        end
        tick();
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd1 || out_freeCnt !== 4'd8) begin
            errors++;
            $display("FAIL single_issue: valid=%b sqN=%0d freeCnt=%0d, want 1/1/8",
                     out_uop.valid, out_uop.sqN, out_freeCnt);
        end
    endtask

    task automatic test_wakeup();
        do_reset();
        set_uop(2, 5, 7'h40, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_uop.valid !== 1'b0) begin
                errors++;
                $display("FAIL wakeup_early: cycle %0d valid=%b, want 0", c, out_uop.valid);
            end
        end
        wb[2] = '{valid: 1'b1, tagDst: 7'd5};
        tick();
        wb[2] = '0;
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd2) begin
            errors++;
            $display("FAIL wakeup_issue: valid=%b sqN=%0d, want 1/2", out_uop.valid, out_uop.sqN);
        end
    endtask

    task automatic test_full();
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_uop(10 + i, 7'h40, 7'h40, 1, 1);
            in_valid = 1'b1;
            tick();
        end
        checks++;
        if (out_full !== 1'b1 || out_freeCnt !== 4'd0) begin
            errors++;
            $display("FAIL full_set: full=%b freeCnt=%0d, want 1/0", out_full, out_freeCnt);
        end
        set_uop(18, 7'h40, 7'h40, 1, 1);
        tick();
        checks++;
        if (out_freeCnt !== 4'd0 || out_uop.valid !== 1'b0) begin
            errors++;
            $display("FAIL full_ignore: freeCnt=%0d valid=%b, want 0/0", out_freeCnt, out_uop.valid);
        end
        stall = 1'b0;
        set_uop(19, 7'h40, 7'h40, 1, 1);
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        checks++;
        if (out_full !== 1'b0 || out_freeCnt !== 4'd1 || out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd10) begin
            errors++;
            $display("FAIL full_release: full=%b freeCnt=%0d valid=%b sqN=%0d, want 0/1/1/10",
                     out_full, out_freeCnt, out_uop.valid, out_uop.sqN);
        end
    endtask

    task automatic test_policy();
        int sqns [8] = '{1, 2, 3, 12, 4, 5, 10, 6};
        int first, second;
`ifdef IQ_OLDEST_FIRST_EN
        first = 10; second = 12;
`else
        first = 12; second = 10;
`endif
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3 || i == 6) set_uop(sqns[i], 7'h40, 7'h40, 1, 1);
            else                  set_uop(sqns[i], 9, 7'h40, 0, 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        stall = 1'b0;
        tick();
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'(first)) begin
            errors++;
            $display("FAIL policy_first: valid=%b sqN=%0d, want 1/%0d", out_uop.valid, out_uop.sqN, first);
        end
        tick();
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'(second)) begin
            errors++;
            $display("FAIL policy_second: valid=%b sqN=%0d, want 1/%0d", out_uop.valid, out_uop.sqN, second);
        end
    endtask

    task automatic test_flush();
        int s [3] = '{4, 7, 9};
        do_reset();
        set_uop(8, 7'h40, 7'h40, 1, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_uop(s[i], 9, 7'h40, 0, 1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd8 || out_freeCnt !== 4'd5) begin
            errors++;
            $display("FAIL flush_setup: valid=%b sqN=%0d freeCnt=%0d, want 1/8/5",
                     out_uop.valid, out_uop.sqN, out_freeCnt);
        end
        br = '{taken: 1'b1, sqN: 7'd6};
        set_uop(11, 7'h40, 7'h40, 1, 1);
        in_valid = 1'b1;
        tick();
        br = '0;
        in_valid = 1'b0;
        checks++;
        if (out_uop.valid !== 1'b0 || out_freeCnt !== 4'd7) begin
            errors++;
            $display("FAIL flush_apply: valid=%b freeCnt=%0d, want 0/7", out_uop.valid, out_freeCnt);
        end
        stall = 1'b0;
        wb[0] = '{valid: 1'b1, tagDst: 7'd9};
        tick();
        wb[0] = '0;
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd4 || out_freeCnt !== 4'd8) begin
            errors++;
            $display("FAIL flush_survivor: valid=%b sqN=%0d freeCnt=%0d, want 1/4/8",
                     out_uop.valid, out_uop.sqN, out_freeCnt);
        end
    endtask

    task automatic test_stall_hold();
        IS_UOp held;
        do_reset();
        set_uop(30, 7'h40, 7'h40, 1, 1);
        in_valid = 1'b1;
        tick();
        set_uop(31, 7'h40, 7'h40, 1, 1);
        tick();
        in_valid = 1'b0;
        held = out_uop;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd30 || out_uop !== held || out_freeCnt !== 4'd7) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b sqN=%0d freeCnt=%0d, want 1/30/7",
                         c, out_uop.valid, out_uop.sqN, out_freeCnt);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_uop.valid !== 1'b1 || out_uop.sqN !== 7'd31 || out_freeCnt !== 4'd8) begin
            errors++;
            $display("FAIL stall_release: valid=%b sqN=%0d freeCnt=%0d, want 1/31/8",
                     out_uop.valid, out_uop.sqN, out_freeCnt);
        end
    endtask

    task automatic test_random();
        int  d;
        bit  blocked;
        do_reset();
        model_reset();
        next_sqn = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            idle_inputs();
            rst = ($urandom_range(0, 199) == 0);
            // keep live sqNs within half the ring so age order stays well defined
            blocked = 0;
            for (int i = 0; i < 8; i++) begin
                d = (int'(next_sqn % 128) - int'(m_uop[i].sqN) + 128) % 128;
                if (m_v[i] && d > 40) blocked = 1;
            end
            if ($urandom_range(0, 9) < 6 && !blocked) begin
                set_uop(int'(next_sqn % 128),
                        $urandom_range(0, 3) == 0 ? 64 + $urandom_range(0, 7) : $urandom_range(0, 7),
                        $urandom_range(0, 3) == 0 ? 64 + $urandom_range(0, 7) : $urandom_range(0, 7),
                        $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                in_valid = 1'b1;
                next_sqn++;
            end
            for (int k = 0; k < 4; k++) begin
                wb[k].valid  = $urandom_range(0, 1) == 1;
                wb[k].tagDst = 7'($urandom_range(0, 7) + ($urandom_range(0, 7) == 0 ? 64 : 0));
            end
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                br.taken = 1'b1;
                br.sqN   = 7'((next_sqn + 128 - $urandom_range(1, 6)) % 128);
            end
            model_step();
            tick();
            checks++;
            if (out_uop.valid !== m_out.valid || (m_out.valid && out_uop !== m_out)
                || out_full !== (m_v.sum() with (int'(item)) == 8)
                || out_freeCnt !== 4'(8 - m_v.sum() with (int'(item)))) begin
                errors++;
                $display("FAIL random cyc %0d: valid=%b sqN=%0d full=%b freeCnt=%0d, want valid=%b sqN=%0d freeCnt=%0d",
                         cyc, out_uop.valid, out_uop.sqN, out_full, out_freeCnt,
                         m_out.valid, m_out.sqN, 8 - m_v.sum() with (int'(item)));
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_issue();
        test_wakeup();
        test_full();
        test_policy();
        test_flush();
        test_stall_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
